// File: rtl/wb_irq_timer_pkg.sv
// Shared constants for the Wishbone prescaled timer: register offsets,
// CTRL bit positions, reset values and the byte-lane helpers.
package wb_irq_timer_pkg;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_COUNT   = 3'd1;
  localparam logic [2:0] OFF_COMPARE = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_SWIRQ   = 3'd4;
  localparam logic [2:0] OFF_PRESC   = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_W      = 3;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Expand the four byte enables into a 32-bit lane mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/wb_irq_timer_presc.sv
// Prescaler: counts 0..presc while enabled and issues a one-cycle tick on
// the cycle it wraps back to 0.
module wb_irq_timer_presc
  import wb_irq_timer_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_r;
  logic [PRESC_W-1:0] cnt_nxt_s;
  logic               wrap_s;

  assign wrap_s = (cnt_r == presc);
  assign tick   = en & wrap_s;

  // Next prescaler count; a PRESC write restarts the count from zero.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clear) begin
      cnt_nxt_s = {PRESC_W{1'b0}};
    end else if (en) begin
      if (wrap_s) begin
        cnt_nxt_s = {PRESC_W{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + PRESC_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {PRESC_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/wb_irq_timer.sv
// Wishbone classic responder with a 32-bit prescaled compare-match timer and a
// software interrupt bit, both mapped onto the CPU irq vector.
module wb_irq_timer
  import wb_irq_timer_pkg::*;
#(
  parameter int IRQ_TIMER = 7,
  parameter int IRQ_SOFT  = 3,
  parameter int PRESC_W   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [31:0] irq
);

  bus_state_e state_r, state_nxt_s;
  logic        ack_r, ack_nxt_s;
  logic [31:0] dat_r, rdata_s;
  logic        req_s, wr_s;
  logic [2:0]  off_s;
  logic [31:0] sel_mask_s;
  logic        unused_adr_s;

  logic [CTRL_W-1:0]  ctrl_r, ctrl_nxt_s;
  logic [31:0]        count_r, count_nxt_s;
  logic [31:0]        compare_r, compare_nxt_s;
  logic               pend_r, pend_nxt_s;
  logic               swirq_r, swirq_nxt_s;
  logic [PRESC_W-1:0] presc_r, presc_nxt_s;

  logic wr_ctrl_s, wr_count_s, wr_compare_s, wr_status_s, wr_swirq_s, wr_presc_s;
  logic tick_s, match_s, w1c_s;
  logic [31:0] irq_s;

  assign off_s        = wb_adr_i[4:2];
  assign unused_adr_s = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
  assign sel_mask_s   = byte_mask(wb_sel_i);
  assign req_s        = wb_cyc_i & wb_stb_i & ~ack_r;

  assign wr_ctrl_s    = wr_s & (off_s == OFF_CTRL);
  assign wr_count_s   = wr_s & (off_s == OFF_COUNT);
  assign wr_compare_s = wr_s & (off_s == OFF_COMPARE);
  assign wr_status_s  = wr_s & (off_s == OFF_STATUS);
  assign wr_swirq_s   = wr_s & (off_s == OFF_SWIRQ);
  assign wr_presc_s   = wr_s & (off_s == OFF_PRESC);

  assign match_s = tick_s & (count_r == compare_r);
  assign w1c_s   = wr_status_s & wb_sel_i[0] & wb_dat_i[0];

  wb_irq_timer_presc #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .en   (ctrl_r[CTRL_EN]),
    .clear(wr_presc_s),
    .presc(presc_r),
    .tick (tick_s)
  );

  // Bus FSM: accept one request, ack it for one cycle, then return to idle.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = 1'b0;
    wr_s        = 1'b0;
    case (state_r)
      BUS_IDLE: begin
        if (req_s) begin
          state_nxt_s = BUS_ACK;
          ack_nxt_s   = 1'b1;
          wr_s        = wb_we_i;
        end else begin
          state_nxt_s = BUS_IDLE;
        end
      end
      BUS_ACK: begin
        state_nxt_s = BUS_IDLE;
      end
      default: begin
        state_nxt_s = BUS_IDLE;
      end
    endcase
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      OFF_CTRL:    rdata_s[CTRL_W-1:0] = ctrl_r;
      OFF_COUNT:   rdata_s = count_r;
      OFF_COMPARE: rdata_s = compare_r;
      OFF_STATUS:  rdata_s[0] = pend_r;
      OFF_SWIRQ:   rdata_s[0] = swirq_r;
      OFF_PRESC:   rdata_s[PRESC_W-1:0] = presc_r;
      default:     rdata_s = 32'd0;
    endcase
  end

  // Register next-state: bus writes, tick updates and the PEND set/clear race.
  always_comb begin
    ctrl_nxt_s    = ctrl_r;
    count_nxt_s   = count_r;
    compare_nxt_s = compare_r;
    pend_nxt_s    = pend_r;
    swirq_nxt_s   = swirq_r;
    presc_nxt_s   = presc_r;

    if (wr_ctrl_s && wb_sel_i[0]) begin
      ctrl_nxt_s = wb_dat_i[CTRL_W-1:0];
    end else begin
      ctrl_nxt_s = ctrl_r;
    end

    // A bus write to COUNT wins over the tick update on the same edge.
    if (wr_count_s) begin
      count_nxt_s = merge_bytes(count_r, wb_dat_i, sel_mask_s);
    end else if (tick_s) begin
      if (match_s && ctrl_r[CTRL_RELOAD]) begin
        count_nxt_s = 32'd0;
      end else begin
        count_nxt_s = count_r + 32'd1;
      end
    end else begin
      count_nxt_s = count_r;
    end

    if (wr_compare_s) begin
      compare_nxt_s = merge_bytes(compare_r, wb_dat_i, sel_mask_s);
    end else begin
      compare_nxt_s = compare_r;
    end

    if (match_s) begin
      pend_nxt_s = 1'b1;
    end else if (w1c_s) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end

    if (wr_swirq_s && wb_sel_i[0]) begin
      swirq_nxt_s = wb_dat_i[0];
    end else begin
      swirq_nxt_s = swirq_r;
    end

    if (wr_presc_s) begin
      presc_nxt_s = (presc_r & ~sel_mask_s[PRESC_W-1:0]) |
                    (wb_dat_i[PRESC_W-1:0] & sel_mask_s[PRESC_W-1:0]);
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  // Interrupt mapping straight from the registers.
  always_comb begin
    irq_s            = 32'd0;
    irq_s[IRQ_TIMER] = pend_r & ctrl_r[CTRL_IE];
    irq_s[IRQ_SOFT]  = swirq_r;
  end

  // State, bus outputs and register file.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= BUS_IDLE;
      ack_r     <= 1'b0;
      dat_r     <= 32'd0;
      ctrl_r    <= {CTRL_W{1'b0}};
      count_r   <= 32'd0;
      compare_r <= COMPARE_RST;
      pend_r    <= 1'b0;
      swirq_r   <= 1'b0;
      presc_r   <= {PRESC_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      ack_r     <= ack_nxt_s;
      dat_r     <= ack_nxt_s ? rdata_s : 32'd0;
      ctrl_r    <= ctrl_nxt_s;
      count_r   <= count_nxt_s;
      compare_r <= compare_nxt_s;
      pend_r    <= pend_nxt_s;
      swirq_r   <= swirq_nxt_s;
      presc_r   <= presc_nxt_s;
    end
  end

  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r;
  assign irq      = irq_s;

endmodule

// File: tb/tb_wb_irq_timer.sv
// Directed bench for wb_irq_timer: each task drives one scenario and compares
// against hand-computed cycle-exact values.
module tb_wb_irq_timer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [31:0] wb_adr_i = 32'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [3:0]  wb_sel_i = 4'd0;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [31:0] irq;

  int checks   = 0;
  int failures = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_irq_timer #(
    .IRQ_TIMER(7),
    .IRQ_SOFT (3),
    .PRESC_W  (16)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i),
    .wb_we_i (wb_we_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .irq     (irq)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus access: request at a negedge, ack expected at the next posedge,
  // then one idle cycle. Returns read data and ack latency (0 = none in 4).
  task automatic xfer(input logic we, input logic [2:0] off, input logic [31:0] wdata,
                      input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = {27'd0, off, 2'b00}; wb_dat_i = wdata; wb_sel_i = sel;
    lat = 0; rdata = 32'd0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(posedge wb_clk_i); #1;
      if (wb_ack_o === 1'b1) begin
        lat = i; rdata = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] d; int l;
    xfer(1'b1, off, data, sel, d, l);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] data);
    int l;
    xfer(1'b0, off, 32'd0, 4'd0, data, l);
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    int l;
    do_reset();
    checks++;
    if ({wb_ack_o, wb_dat_o, irq} !== 65'd0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b dat=%h irq=%h, expected all 0", wb_ack_o, wb_dat_o, irq);
    end
    for (int off = 0; off < 8; off++) begin
      e = (off == 2) ? 32'hFFFF_FFFF : 32'd0;
      xfer(1'b0, 3'(off), 32'd0, 4'd0, d, l);
      checks++;
      if (l !== 1) begin
        failures++;
        $display("FAIL reset_ack_latency off=%0d: got %0d cycles, expected 1", off, l);
      end
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL reset_read off=%0d: got %h, expected %h", off, d, e);
      end
    end
    checks++;
    if ({wb_ack_o, wb_dat_o} !== 33'd0) begin
      failures++;
      $display("FAIL idle_bus: ack=%b dat=%h, expected 0/0", wb_ack_o, wb_dat_o);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    do_reset();
    wr(3'd5, 32'd0, 4'hF);
    wr(3'd2, 32'd5, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'h5, 4'hF);
    repeat (4) @(posedge wb_clk_i);
    checks++;
    if (irq !== 32'd0) begin failures++; $display("FAIL oneshot_before_match: irq=%h, expected 0", irq); end
    @(posedge wb_clk_i); #1;
    checks++;
    if (irq !== 32'h80) begin failures++; $display("FAIL oneshot_irq: irq=%h, expected 00000080", irq); end
    rd(3'd1, d);
    checks++;
    if (d !== 32'd6) begin failures++; $display("FAIL oneshot_count_after: got %h, expected 6", d); end
    rd(3'd3, d);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL oneshot_status: got %h, expected 1", d); end
    wr(3'd3, 32'd1, 4'h1);
    checks++;
    if (irq !== 32'd0) begin failures++; $display("FAIL oneshot_w1c: irq=%h, expected 0", irq); end
    rd(3'd1, d);
    checks++;
    if (d !== 32'd12) begin failures++; $display("FAIL oneshot_count_runs: got %h, expected 0000000c", d); end
  endtask

  task automatic test_reload();
    logic [31:0] d;
    logic [31:0] exp_seq [8];
    exp_seq = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'd0};
    do_reset();
    wr(3'd5, 32'd3, 4'hF);
    wr(3'd2, 32'd2, 4'hF);
    wr(3'd0, 32'h7, 4'hF);
    for (int k = 0; k < 8; k++) begin
      rd(3'd1, d);
      checks++;
      if (d !== exp_seq[k]) begin
        failures++;
        $display("FAIL reload_seq[%0d]: got %h, expected %h", k, d, exp_seq[k]);
      end
    end
    checks++;
    if (irq !== 32'h80) begin failures++; $display("FAIL reload_pend1: irq=%h, expected 00000080", irq); end
    wr(3'd3, 32'd1, 4'h1);
    checks++;
    if (irq !== 32'd0) begin failures++; $display("FAIL reload_clear: irq=%h, expected 0", irq); end
    repeat (4) @(posedge wb_clk_i);
    checks++;
    if (irq !== 32'd0) begin failures++; $display("FAIL reload_before_wrap2: irq=%h, expected 0", irq); end
    @(posedge wb_clk_i); #1;
    checks++;
    if (irq !== 32'h80) begin failures++; $display("FAIL reload_pend2: irq=%h, expected 00000080", irq); end
    rd(3'd1, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reload_wrap2_count: got %h, expected 0", d); end
  endtask

  task automatic test_byte_select();
    logic [31:0] d;
    do_reset();
    wr(3'd2, 32'h1122_3344, 4'hF);
    wr(3'd2, 32'hAABB_CCDD, 4'b0101);
    rd(3'd2, d);
    checks++;
    if (d !== 32'h11BB_33DD) begin failures++; $display("FAIL bytesel_compare: got %h, expected 11bb33dd", d); end
    wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    rd(3'd5, d);
    checks++;
    if (d !== 32'h0000_FFFF) begin failures++; $display("FAIL presc_width: got %h, expected 0000ffff", d); end
    wr(3'd5, 32'h0000_1200, 4'b0010);
    rd(3'd5, d);
    checks++;
    if (d !== 32'h0000_12FF) begin failures++; $display("FAIL presc_bytesel: got %h, expected 000012ff", d); end
    wr(3'd6, 32'hFFFF_FFFF, 4'hF);
    rd(3'd6, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL unmapped_read: got %h, expected 0", d); end
    rd(3'd2, d);
    checks++;
    if (d !== 32'h11BB_33DD) begin failures++; $display("FAIL unmapped_no_alias: got %h, expected 11bb33dd", d); end
    wr(3'd0, 32'hFFFF_FFFF, 4'b1110);
    rd(3'd0, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL ctrl_sel0_low: got %h, expected 0", d); end
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    rd(3'd0, d);
    checks++;
    if (d !== 32'h7) begin failures++; $display("FAIL ctrl_unused_bits: got %h, expected 7", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    do_reset();
    wr(3'd5, 32'd0, 4'hF);
    wr(3'd2, 32'd5, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'h5, 4'hF);
    repeat (4) @(posedge wb_clk_i);
    wr(3'd3, 32'd1, 4'h1);
    checks++;
    if (irq !== 32'h80) begin failures++; $display("FAIL collision_pend_kept: irq=%h, expected 00000080", irq); end
    rd(3'd3, d);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL collision_status: got %h, expected 1", d); end
    wr(3'd3, 32'hFFFF_FFFF, 4'b1110);
    checks++;
    if (irq !== 32'h80) begin failures++; $display("FAIL w1c_sel0_low: irq=%h, expected 00000080", irq); end
    wr(3'd1, 32'h100, 4'hF);
    rd(3'd1, d);
    checks++;
    if (d !== 32'h101) begin failures++; $display("FAIL count_write_vs_tick: got %h, expected 00000101", d); end
  endtask

  task automatic test_swirq_wrap();
    logic [31:0] d;
    do_reset();
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h10; wb_dat_i = 32'd1; wb_sel_i = 4'h1;
    @(posedge wb_clk_i); #1;
    checks++;
    if ({wb_ack_o, irq} !== {1'b1, 32'h8}) begin
      failures++;
      $display("FAIL swirq_next_cycle: ack=%b irq=%h, expected 1/00000008", wb_ack_o, irq);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
    rd(3'd4, d);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL swirq_read: got %h, expected 1", d); end
    wr(3'd4, 32'd0, 4'h1);
    checks++;
    if (irq !== 32'd0) begin failures++; $display("FAIL swirq_clear: irq=%h, expected 0", irq); end
    wr(3'd5, 32'd3, 4'hF);
    wr(3'd2, 32'h10, 4'hF);
    wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    wr(3'd0, 32'h5, 4'hF);
    rd(3'd1, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_hold_a: got %h, expected ffffffff", d); end
    rd(3'd1, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_hold_b: got %h, expected ffffffff", d); end
    rd(3'd1, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL wrap_count: got %h, expected 0", d); end
    checks++;
    if (irq !== 32'd0) begin failures++; $display("FAIL wrap_no_irq: irq=%h, expected 0", irq); end
    rd(3'd3, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL wrap_no_pend: got %h, expected 0", d); end
    wr(3'd0, 32'd0, 4'hF);
    rd(3'd1, d);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL en_hold_a: got %h, expected 1", d); end
    rd(3'd1, d);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL en_hold_b: got %h, expected 1", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        exp_ack;
    do_reset();
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h8;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      exp_ack = (i % 2 == 0) ? 1'b1 : 1'b0;
      checks++;
      if ({wb_ack_o, wb_dat_o} !== {exp_ack, exp_ack ? 32'hFFFF_FFFF : 32'd0}) begin
        failures++;
        $display("FAIL held_strobe[%0d]: ack=%b dat=%h, expected ack=%b", i, wb_ack_o, wb_dat_o, exp_ack);
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h4; wb_dat_i = 32'h1234; wb_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL cancel_no_ack: ack=%b, expected 0", wb_ack_o); end
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rd(3'd1, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL cancel_no_commit: got %h, expected 0", d); end
    wr(3'd2, 32'h55, 4'hF);
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h4; wb_dat_i = 32'h77; wb_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    checks++;
    if (wb_ack_o !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_ack: ack=%b, expected 1", wb_ack_o); end
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    checks++;
    if ({wb_ack_o, wb_dat_o} !== 33'd0) begin
      failures++;
      $display("FAIL rst_mid_ack: ack=%b dat=%h, expected 0/0", wb_ack_o, wb_dat_o);
    end
    @(posedge wb_clk_i); #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL rst_discard: ack=%b, expected 0", wb_ack_o); end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rd(3'd1, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL rst_count: got %h, expected 0", d); end
    rd(3'd2, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_compare: got %h, expected ffffffff", d); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_byte_select();
    test_collision();
    test_swirq_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_irq_timer.md
# wb_irq_timer

Wishbone classic-cycle responder that provides a 32-bit prescaled timer with compare-match interrupt and a software interrupt, driving the `irq` vector of `nanorv32_wb`. It sits on the shared `wb_m2s_*` / `wb_s2m_*` bus beside `wb_ram`. Address decode into its window is done externally. The block answers every strobe it receives.

## Interface
Parameters:
- `IRQ_TIMER`, 7: bit index of `irq` driven by the timer pending flag.
- `IRQ_SOFT`, 3: bit index of `irq` driven by the software interrupt bit; must differ from `IRQ_TIMER`.
- `PRESC_W`, 16: width of the prescaler register and counter.

Ports:
- `wb_clk_i`, in, 1: the single clock.
- `wb_rst_i`, in, 1: reset, synchronous and active-high.
- `wb_adr_i`, in, 32: byte address; only [4:2] decoded.
- `wb_dat_i`, in, 32: write data.
- `wb_sel_i`, in, 4: byte enables for writes.
- `wb_we_i`, in, 1: write enable.
- `wb_cyc_i`, in, 1: cycle valid.
- `wb_stb_i`, in, 1: strobe.
- `wb_dat_o`, out, 32: read data.
- `wb_ack_o`, out, 1: acknowledge.
- `irq`, out, 32: interrupt vector to the CPU.

## Operation
- Register map (word offset via adr[4:2]):
  - 0x00 CTRL [2:0]: bit0 EN, bit1 RELOAD, bit2 IE.
  - 0x04 COUNT [31:0].
  - 0x08 COMPARE [31:0].
  - 0x0C STATUS: bit0 PEND; write-1-to-clear.
  - 0x10 SWIRQ: bit0.
  - 0x14 PRESC [PRESC_W-1:0].
  - 0x18 and 0x1C read 0; writes to them are ignored.
  - Unused bits read 0.
- Reset values:
  - COMPARE = 0xFFFF_FFFF.
  - All other registers, the prescaler counter, `wb_ack_o`, `wb_dat_o` and `irq` are 0.
- Writes honour `wb_sel_i` per byte. For STATUS, only sel[0] is relevant.
- Prescaler, while EN = 1:
  - The prescaler counter increments each cycle.
  - When it equals PRESC, it returns to 0 and a tick is issued.
  - PRESC = 0 therefore ticks every cycle.
  - EN = 0 holds both counters.
- Tick behaviour:
  - If COUNT == COMPARE on a tick: PEND is set, then COUNT goes to 0 if RELOAD = 1, else COUNT + 1.
  - Otherwise COUNT goes to COUNT + 1, wrapping from 0xFFFF_FFFF to 0 without setting PEND.
- Priority rules:
  - A bus write to COUNT overrides the tick update in the same cycle.
  - A write to PRESC also clears the prescaler counter.
  - PEND set by a match beats a W1C in the same cycle, so PEND stays 1.
- `irq[IRQ_TIMER]` = PEND & IE. `irq[IRQ_SOFT]` = SWIRQ[0]. All other bits are 0.
- `irq` is combinational from the registers, with no added latency.

## Timing
- A request is `wb_cyc_i & wb_stb_i & !wb_ack_o`. At the next edge:
  - `wb_ack_o` rises for exactly one cycle.
  - Write data is committed.
  - `wb_dat_o` is loaded with the addressed register.
- Read/write latency is 1 cycle.
- With a held strobe, the throughput is one ack every 2 cycles: no back-to-back ack.
- `wb_dat_o` is 0 in every cycle where `wb_ack_o` = 0.
- A read returns the register value from before the acking edge, not the same-edge tick update.
- Dropping `wb_cyc_i` mid-request (before ack) cancels it: no commit and no ack.
- Reset asserted mid-transaction:
  - The ack is cleared on the next edge and all registers return to reset values.
  - The pending request is discarded.
- A PEND change is visible on `irq` in the cycle after the tick edge.

## Structure
- Shared package `wb_irq_timer_pkg`: register offset constants (CTRL, COUNT, COMPARE, STATUS, SWIRQ, PRESC), CTRL bit positions, and the COMPARE reset constant.
- Sub-module `wb_irq_timer_presc`:
  - Inputs: `PRESC_W`-wide prescaler counter, EN, PRESC value, clear.
  - Output: `tick`.
- The top level holds the bus FSM (IDLE / ACK), the register file, the COUNT/PEND logic and the irq mapping.

## Test plan
- Reset:
  - Stimulus: reset, then read every offset.
  - Required: COMPARE = 0xFFFF_FFFF, everything else 0, `irq` = 0, each read acked exactly 1 cycle after the strobe.
- One-shot match:
  - Stimulus: PRESC = 0, COMPARE = 5, COUNT = 0, CTRL = 0b101.
  - Required: PEND sets on the 6th tick, `irq[7]` = 1 one cycle later, COUNT continues to 6, 7, …; a write of 1 to STATUS drops `irq[7]`.
- Reload and prescale:
  - Stimulus: PRESC = 3, COMPARE = 2, CTRL = 0b111.
  - Required: COUNT sequence 0, 1, 2, 0 with each value held 4 cycles; PEND set at every wrap to 0.
- Byte select:
  - Stimulus: COMPARE = 0x1122_3344, then write 0xAABB_CCDD with sel = 0b0101.
  - Required: read returns 0x11BB_33DD.
- Collisions:
  - Stimulus: W1C to STATUS on the match tick; COUNT write on a tick edge.
  - Required: PEND stays 1; COUNT takes the written value.
- Software irq and wrap:
  - Stimulus: SWIRQ = 1; separately COUNT = 0xFFFF_FFFF with COMPARE = 0x10.
  - Required: `irq[3]` = 1 the next cycle; on the next tick COUNT = 0 with PEND = 0.
